// File: rtl/vga_timing_pkg.sv
// Shared constants for the display timing path: polarity levels, standard mode
// timings and a helper that sums the four segments of a line or frame.
package vga_timing_pkg;

  localparam bit ACTIVE_LOW  = 1'b0;
  localparam bit ACTIVE_HIGH = 1'b1;

  function automatic int unsigned vga_total(input int unsigned active_len,
                                            input int unsigned fp_len,
                                            input int unsigned sync_len,
                                            input int unsigned bp_len);
    return active_len + fp_len + sync_len + bp_len;
  endfunction

  // 640x480@60, 25.175 MHz pixel clock
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;
  localparam bit          VGA640_H_POL    = ACTIVE_LOW;
  localparam bit          VGA640_V_POL    = ACTIVE_LOW;

  // 800x600@60, 40 MHz pixel clock
  localparam int unsigned SVGA800_H_ACTIVE = 800;
  localparam int unsigned SVGA800_H_FP     = 40;
  localparam int unsigned SVGA800_H_SYNC   = 128;
  localparam int unsigned SVGA800_H_BP     = 88;
  localparam int unsigned SVGA800_V_ACTIVE = 600;
  localparam int unsigned SVGA800_V_FP     = 1;
  localparam int unsigned SVGA800_V_SYNC   = 4;
  localparam int unsigned SVGA800_V_BP     = 23;
  localparam bit          SVGA800_H_POL    = ACTIVE_HIGH;
  localparam bit          SVGA800_V_POL    = ACTIVE_HIGH;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus combinational sync and
// active-window decode. Used once per line and once per frame.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = ACTIVE_LOW,
  parameter int unsigned W      = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic         wrap,
  output logic [W-1:0] count,
  output logic         sync_raw,
  output logic         active
);

  localparam int unsigned TOTAL = vga_total(ACTIVE, FP, SYNC, BP);

  logic [W-1:0] count_q, count_d;
  logic [31:0]  countWide;

  // Compare at 32 bits so a segment ending exactly at 2^W cannot truncate
  assign countWide = 32'(count_q);
  assign wrap      = inc && (countWide == TOTAL - 1);
  assign sync_raw  = (countWide >= ACTIVE + FP && countWide < ACTIVE + FP + SYNC) ? POL : ~POL;
  assign active    = (countWide < ACTIVE);
  assign count     = count_q;

  always_comb begin
    count_d = count_q;
    if (inc) count_d = wrap ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised display timing generator: pixel divider, horizontal/vertical
// counters, frame counter and one aligned output register stage.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = ACTIVE_LOW,
  parameter bit          V_POL    = ACTIVE_LOW,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned FRM_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] pixel_x,
  output logic [CNT_W-1:0] pixel_y,
  output logic             line_start,
  output logic             frame_start,
  output logic [FRM_W-1:0] frame_cnt
);

  localparam int unsigned H_TOTAL  = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL  = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 1 || H_TOTAL > (1 << CNT_W) || V_TOTAL > (1 << CNT_W)) begin : g_bad_params
    $error("vga_timing_gen: CLK_DIV must be >= 1 and both totals must fit in CNT_W bits");
  end

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_int;
  logic             h_wrap, v_wrap, h_sync_raw, v_sync_raw, h_active, v_active;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [FRM_W-1:0] frm_q;
  logic             newline_q, newframe_q;
  logic             hsync_q, vsync_q, video_on_q, p_tick_q, line_start_q, frame_start_q;
  logic [CNT_W-1:0] pixel_x_q, pixel_y_q;
  logic [FRM_W-1:0] frame_cnt_q;

  assign tick_int = en && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    if (en) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL), .W(CNT_W)
  ) u_h_axis (
    .clk(clk), .reset(reset), .inc(tick_int), .wrap(h_wrap),
    .count(h_cnt), .sync_raw(h_sync_raw), .active(h_active)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL), .W(CNT_W)
  ) u_v_axis (
    .clk(clk), .reset(reset), .inc(h_wrap), .wrap(v_wrap),
    .count(v_cnt), .sync_raw(v_sync_raw), .active(v_active)
  );

  // newline/newframe mark that the counters just landed on 0, so the strobe
  // is emitted alongside the registered coordinate; they start set so the
  // first edge after reset announces (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      frm_q         <= '0;
      newline_q     <= 1'b1;
      newframe_q    <= 1'b1;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      video_on_q    <= 1'b0;
      p_tick_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      pixel_x_q     <= '0;
      pixel_y_q     <= '0;
      frame_cnt_q   <= '0;
    end else begin
      div_q         <= div_d;
      if (v_wrap) frm_q <= frm_q + 1'b1;
      newline_q     <= h_wrap;
      newframe_q    <= v_wrap;
      hsync_q       <= h_sync_raw;
      vsync_q       <= v_sync_raw;
      video_on_q    <= h_active && v_active;
      p_tick_q      <= tick_int;
      line_start_q  <= newline_q;
      frame_start_q <= newframe_q;
      pixel_x_q     <= h_cnt;
      pixel_y_q     <= v_cnt;
      frame_cnt_q   <= frm_q;
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign p_tick      = p_tick_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
